// File: rtl/risc16ba_pkg.sv
// Shared encodings and pipeline control types for the risc16ba core.
package risc16ba_pkg;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_ANDI = 5'b00101;
  localparam logic [4:0] OP_ORI  = 5'b00110;
  localparam logic [4:0] OP_LLI  = 5'b01000;
  localparam logic [4:0] OP_LUI  = 5'b01001;
  localparam logic [4:0] OP_BEQZ = 5'b10000;
  localparam logic [4:0] OP_BNEZ = 5'b10001;
  localparam logic [4:0] OP_BMI  = 5'b10010;
  localparam logic [4:0] OP_BPL  = 5'b10011;
  localparam logic [4:0] OP_J    = 5'b11000;
  localparam logic [4:0] OP_HLT  = 5'b11111;

  localparam logic [4:0] FN_MV  = 5'b00001;
  localparam logic [4:0] FN_NOT = 5'b00010;
  localparam logic [4:0] FN_XOR = 5'b00011;
  localparam logic [4:0] FN_ADD = 5'b00100;
  localparam logic [4:0] FN_SUB = 5'b00101;
  localparam logic [4:0] FN_SL  = 5'b01000;
  localparam logic [4:0] FN_SR  = 5'b01001;
  localparam logic [4:0] FN_AND = 5'b01010;
  localparam logic [4:0] FN_OR  = 5'b01011;
  localparam logic [4:0] FN_MUL = 5'b01100;
  localparam logic [4:0] FN_ST  = 5'b10000;
  localparam logic [4:0] FN_LD  = 5'b10001;
  localparam logic [4:0] FN_SBU = 5'b10010;
  localparam logic [4:0] FN_LBU = 5'b10011;

  typedef enum logic [1:0] {ST_FILL = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state0_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_MV = 4'd1, ALU_NOT = 4'd2, ALU_XOR = 4'd3, ALU_ADD = 4'd4,
    ALU_SUB = 4'd5, ALU_SL = 4'd6, ALU_SR = 4'd7, ALU_AND = 4'd8, ALU_OR = 4'd9, ALU_MUL = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0, MEM_ST = 3'd1, MEM_LD = 3'd2, MEM_SB = 3'd3, MEM_LB = 3'd4
  } mem_op_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0, BR_EQZ = 3'd1, BR_NEZ = 3'd2, BR_MI = 3'd3, BR_PL = 3'd4, BR_J = 3'd5
  } br_op_t;

  typedef struct packed {
    alu_op_t    alu;
    mem_op_t    mem;
    br_op_t     br;
    logic       hlt;
    logic       use_imm;
    logic       we;
    logic [2:0] rd;
  } ctl_t;

  localparam ctl_t CTL_NOP = '{alu: ALU_NOP, mem: MEM_NONE, br: BR_NONE, hlt: 1'b0,
                               use_imm: 1'b0, we: 1'b0, rd: 3'd0};

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/risc16ba_reg_file.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port.
module risc16ba_reg_file
  import risc16ba_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr1,
  input  logic [2:0]  raddr2,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2
);

  logic [15:0] regs [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/risc16ba_cpu.sv
// risc16ba_cpu: 3-stage (IF/RF/EX) 16-bit RISC core with separate instruction and data buses.
// Define RISC16BA_MUL_EN to enable the single-cycle mul instruction (R fn 01100).
module risc16ba_cpu
  import risc16ba_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] idin,
  output logic [15:0] iaddr,
  output logic        ioe,
  input  logic [15:0] ddin,
  output logic [15:0] ddout,
  output logic [15:0] daddr,
  output logic        doe,
  output logic        dwe0,
  output logic        dwe1
);

  state0_t     state0, state_nxt;
  logic        finish, active, ex_wr, taken;
  logic [15:0] if_pc, if_ir, if_ipc;
  ctl_t        dec, ex_ctl;
  logic [15:0] dec_imm, rdata1, rdata2, fwd1, fwd2;
  logic [15:0] ex_pc, rf_treg1, rf_treg2, rf_imm;
  logic [15:0] opb, alu_out, mem_addr, load_data, ex_result, target;

  assign finish = (state0 == ST_HALT);
  assign active = !rst && !finish;
  assign ex_wr  = active && ex_ctl.we;
  assign iaddr  = if_pc;
  assign ioe    = active;

  always_ff @(posedge clk) begin
    if (rst) state0 <= ST_FILL;
    else     state0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state0;
    case (state0)
      ST_FILL: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ex_ctl.hlt ? ST_HALT : ST_RUN;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    dec         = CTL_NOP;
    dec_imm     = 16'h0000;
    dec.rd      = if_ir[10:8];
    case (if_ir[15:11])
      OP_R: begin
        dec.we = 1'b1;
        case (if_ir[4:0])
          FN_MV:  dec.alu = ALU_MV;
          FN_NOT: dec.alu = ALU_NOT;
          FN_XOR: dec.alu = ALU_XOR;
          FN_ADD: dec.alu = ALU_ADD;
          FN_SUB: dec.alu = ALU_SUB;
          FN_SL:  dec.alu = ALU_SL;
          FN_SR:  dec.alu = ALU_SR;
          FN_AND: dec.alu = ALU_AND;
          FN_OR:  dec.alu = ALU_OR;
`ifdef RISC16BA_MUL_EN
          FN_MUL: dec.alu = ALU_MUL;
`endif
          FN_ST:  begin dec.mem = MEM_ST; dec.we = 1'b0; end
          FN_LD:  dec.mem = MEM_LD;
          FN_SBU: begin dec.mem = MEM_SB; dec.we = 1'b0; end
          FN_LBU: dec.mem = MEM_LB;
          default: dec.we = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.alu = ALU_ADD; dec.we = 1'b1; dec.use_imm = 1'b1; dec_imm = sext8(if_ir[7:0]); end
      OP_ANDI: begin dec.alu = ALU_AND; dec.we = 1'b1; dec.use_imm = 1'b1; dec_imm = {8'h00, if_ir[7:0]}; end
      OP_ORI:  begin dec.alu = ALU_OR;  dec.we = 1'b1; dec.use_imm = 1'b1; dec_imm = {8'h00, if_ir[7:0]}; end
      OP_LLI:  begin dec.alu = ALU_MV;  dec.we = 1'b1; dec.use_imm = 1'b1; dec_imm = {8'h00, if_ir[7:0]}; end
      OP_LUI:  begin dec.alu = ALU_MV;  dec.we = 1'b1; dec.use_imm = 1'b1; dec_imm = {if_ir[7:0], 8'h00}; end
      OP_BEQZ: begin dec.br = BR_EQZ; dec_imm = sext8(if_ir[7:0]); end
      OP_BNEZ: begin dec.br = BR_NEZ; dec_imm = sext8(if_ir[7:0]); end
      OP_BMI:  begin dec.br = BR_MI;  dec_imm = sext8(if_ir[7:0]); end
      OP_BPL:  begin dec.br = BR_PL;  dec_imm = sext8(if_ir[7:0]); end
      OP_J:    begin dec.br = BR_J;   dec_imm = {{5{if_ir[10]}}, if_ir[10:0]}; end
      OP_HLT:  dec.hlt = 1'b1;
      default: dec = CTL_NOP;
    endcase
  end

  risc16ba_reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (ex_wr),
    .waddr  (ex_ctl.rd),
    .wdata  (ex_result),
    .raddr1 (if_ir[10:8]),
    .raddr2 (if_ir[7:5]),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // The instruction in EX writes back on the same edge RF latches, so bypass it.
  assign fwd1 = (ex_wr && ex_ctl.rd == if_ir[10:8]) ? ex_result : rdata1;
  assign fwd2 = (ex_wr && ex_ctl.rd == if_ir[7:5])  ? ex_result : rdata2;

  always_comb begin
    opb     = ex_ctl.use_imm ? rf_imm : rf_treg2;
    alu_out = rf_treg1;
    case (ex_ctl.alu)
      ALU_MV:  alu_out = opb;
      ALU_NOT: alu_out = ~opb;
      ALU_XOR: alu_out = rf_treg1 ^ opb;
      ALU_ADD: alu_out = rf_treg1 + opb;
      ALU_SUB: alu_out = rf_treg1 - opb;
      ALU_SL:  alu_out = {opb[14:0], 1'b0};
      ALU_SR:  alu_out = {1'b0, opb[15:1]};
      ALU_AND: alu_out = rf_treg1 & opb;
      ALU_OR:  alu_out = rf_treg1 | opb;
`ifdef RISC16BA_MUL_EN
      ALU_MUL: alu_out = rf_treg1 * opb;
`endif
      default: alu_out = rf_treg1;
    endcase
    mem_addr = (ex_ctl.mem == MEM_ST || ex_ctl.mem == MEM_SB) ? rf_treg1 : rf_treg2;
    if (ex_ctl.mem == MEM_LB) load_data = mem_addr[0] ? {8'h00, ddin[7:0]} : {8'h00, ddin[15:8]};
    else                      load_data = ddin;
    ex_result = (ex_ctl.mem == MEM_LD || ex_ctl.mem == MEM_LB) ? load_data : alu_out;
    case (ex_ctl.br)
      BR_EQZ:  taken = (rf_treg1 == 16'h0000);
      BR_NEZ:  taken = (rf_treg1 != 16'h0000);
      BR_MI:   taken = rf_treg1[15];
      BR_PL:   taken = !rf_treg1[15];
      BR_J:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    taken  = taken && active;
    target = ex_pc + 16'd2 + rf_imm;
  end

  always_comb begin
    daddr = 16'h0000;
    ddout = 16'h0000;
    doe   = 1'b0;
    dwe0  = 1'b0;
    dwe1  = 1'b0;
    if (active) begin
      case (ex_ctl.mem)
        MEM_ST: begin daddr = mem_addr; ddout = rf_treg2; dwe0 = 1'b1; dwe1 = 1'b1; end
        MEM_LD: begin daddr = mem_addr; doe = 1'b1; end
        MEM_SB: begin
          daddr = mem_addr;
          ddout = {rf_treg2[7:0], rf_treg2[7:0]};
          dwe0  = !mem_addr[0];
          dwe1  = mem_addr[0];
        end
        MEM_LB: begin daddr = mem_addr; doe = 1'b1; end
        default: daddr = 16'h0000;
      endcase
    end else begin
      doe = 1'b0;
    end
  end

  // Pipeline advance; a taken branch squashes the two younger instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc    <= RESET_PC;
      if_ir    <= NOP_WORD;
      if_ipc   <= 16'h0000;
      ex_ctl   <= CTL_NOP;
      ex_pc    <= 16'h0000;
      rf_treg1 <= 16'h0000;
      rf_treg2 <= 16'h0000;
      rf_imm   <= 16'h0000;
    end else if (!finish) begin
      if (taken) begin
        if_pc  <= target;
        if_ir  <= NOP_WORD;
        ex_ctl <= CTL_NOP;
      end else begin
        if_pc    <= if_pc + 16'd2;
        if_ir    <= idin;
        if_ipc   <= if_pc;
        ex_ctl   <= dec;
        ex_pc    <= if_ipc;
        rf_treg1 <= fwd1;
        rf_treg2 <= fwd2;
        rf_imm   <= dec_imm;
      end
    end
  end

endmodule

// File: tb/tb_risc16ba_cpu.sv
// Directed program bench for risc16ba_cpu; data-bus events are checked against a queue of expected accesses.
module tb_risc16ba_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] idin, iaddr, ddin, ddout, daddr;
  logic        ioe, doe, dwe0, dwe1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  we;
    logic        oe;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          first_st_cyc = -1;
  int          pa = 0;
  int          hlt_addr = 0;
  logic        halted;

  risc16ba_cpu dut (
    .clk(clk), .rst(rst), .idin(idin), .iaddr(iaddr), .ioe(ioe),
    .ddin(ddin), .ddout(ddout), .daddr(daddr), .doe(doe), .dwe0(dwe0), .dwe1(dwe1)
  );

  always #5 clk = ~clk;

  assign idin = imem[iaddr[8:1]];
  assign ddin = dmem[daddr[8:1]];

  always @(posedge clk) begin
    if (dwe0) dmem[daddr[8:1]][15:8] <= ddout[15:8];
    if (dwe1) dmem[daddr[8:1]][7:0]  <= ddout[7:0];
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [2:0] rd, input logic [2:0] rs, input logic [4:0] fn);
    return {5'b00000, rd, rs, fn};
  endfunction

  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic ins(input logic [15:0] w);
    imem[pa] = w;
    pa++;
  endtask

  task automatic exp_ev(input logic [15:0] a, input logic [15:0] d, input logic [1:0] we, input logic oe);
    ev_t e;
    e.addr = a; e.data = d; e.we = we; e.oe = oe;
    exp_q.push_back(e);
  endtask

  // Every data-bus access must match the next expected one, in order.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (dwe0 || dwe1 || doe)) begin
      if ((dwe0 || dwe1) && first_st_cyc < 0) first_st_cyc = cyc;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL mem_unexpected observed=%h/%h expected=none", daddr, ddout);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_ctl", {13'd0, dwe0, dwe1, doe, daddr}, {13'd0, e.we, e.oe, e.addr});
        if (e.we != 2'b00) check("mem_data", {16'd0, ddout}, {16'd0, e.data});
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
    ins(enc_i(5'b01000, 3'd1, 8'h05));          // lli r1,5
    ins(enc_i(5'b00100, 3'd1, 8'hFF));          // addi r1,-1
    ins(enc_r(3'd2, 3'd1, 5'b00100));           // add r2,r1
    ins(enc_i(5'b01000, 3'd7, 8'h10));          // lli r7,0x10
    ins(enc_r(3'd7, 3'd1, 5'b10000)); exp_ev(16'h0010, 16'h0004, 2'b11, 1'b0);
    ins(enc_i(5'b00100, 3'd7, 8'h02));
    ins(enc_r(3'd7, 3'd2, 5'b10000)); exp_ev(16'h0012, 16'h0004, 2'b11, 1'b0);
    ins(enc_i(5'b01001, 3'd3, 8'hC0));          // lui r3,C0
    ins(enc_i(5'b01000, 3'd4, 8'hAB));
    ins(enc_r(3'd3, 3'd4, 5'b10000)); exp_ev(16'hC000, 16'h00AB, 2'b11, 1'b0);
    ins(enc_r(3'd5, 3'd3, 5'b10001)); exp_ev(16'hC000, 16'h0000, 2'b00, 1'b1);
    ins(enc_r(3'd7, 3'd5, 5'b10000)); exp_ev(16'h0012, 16'h00AB, 2'b11, 1'b0);
    ins(enc_i(5'b00110, 3'd3, 8'h01));          // r3=C001
    ins(enc_i(5'b01001, 3'd4, 8'h12));
    ins(enc_i(5'b00110, 3'd4, 8'hEF));          // r4=12EF
    ins(enc_r(3'd3, 3'd4, 5'b10010)); exp_ev(16'hC001, 16'hEFEF, 2'b01, 1'b0);
    ins(enc_r(3'd6, 3'd3, 5'b10011)); exp_ev(16'hC001, 16'h0000, 2'b00, 1'b1);
    ins(enc_r(3'd7, 3'd6, 5'b10000)); exp_ev(16'h0012, 16'h00EF, 2'b11, 1'b0);
    ins(enc_r(3'd7, 3'd1, 5'b10010)); exp_ev(16'h0012, 16'h0404, 2'b10, 1'b0);
    ins(enc_r(3'd6, 3'd7, 5'b10011)); exp_ev(16'h0012, 16'h0000, 2'b00, 1'b1);
    ins(enc_r(3'd7, 3'd6, 5'b10000)); exp_ev(16'h0012, 16'h0004, 2'b11, 1'b0);
    ins(enc_r(3'd1, 3'd4, 5'b00011));           // xor -> 12EB
    ins(enc_r(3'd1, 3'd2, 5'b00101));           // sub -> 12E7
    ins(enc_r(3'd2, 3'd1, 5'b00010));           // not -> ED18
    ins(enc_r(3'd2, 3'd2, 5'b01000));           // sl  -> DA30
    ins(enc_r(3'd3, 3'd2, 5'b01001));           // sr  -> 6D18
    ins(enc_r(3'd3, 3'd4, 5'b01010));           // and -> 0008
    ins(enc_r(3'd3, 3'd1, 5'b01011));           // or  -> 12EF
    ins(enc_r(3'd5, 3'd3, 5'b00001));           // mv
    ins(enc_i(5'b00101, 3'd5, 8'h0F));          // andi -> 000F
    ins(enc_r(3'd7, 3'd5, 5'b10000)); exp_ev(16'h0012, 16'h000F, 2'b11, 1'b0);
    ins(enc_r(3'd7, 3'd2, 5'b10000)); exp_ev(16'h0012, 16'hDA30, 2'b11, 1'b0);
    ins(enc_r(3'd7, 3'd1, 5'b10000)); exp_ev(16'h0012, 16'h12E7, 2'b11, 1'b0);
    ins(enc_i(5'b01001, 3'd1, 8'h01));
    ins(enc_i(5'b00110, 3'd1, 8'h02));          // r1=0102
    ins(enc_i(5'b01001, 3'd2, 8'h01));          // r2=0100
    ins(enc_r(3'd1, 3'd2, 5'b01100));           // mul
`ifdef RISC16BA_MUL_EN
    ins(enc_r(3'd7, 3'd1, 5'b10000)); exp_ev(16'h0012, 16'h0200, 2'b11, 1'b0);
`else
    ins(enc_r(3'd7, 3'd1, 5'b10000)); exp_ev(16'h0012, 16'h0102, 2'b11, 1'b0);
`endif
    ins(enc_i(5'b01000, 3'd1, 8'h00));
    ins(enc_i(5'b10000, 3'd1, 8'h04));          // beqz taken
    ins(enc_i(5'b01000, 3'd2, 8'h55));
    ins(enc_i(5'b01000, 3'd2, 8'h66));
    ins(enc_r(3'd7, 3'd2, 5'b10000)); exp_ev(16'h0012, 16'h0100, 2'b11, 1'b0);
    ins(enc_i(5'b10001, 3'd1, 8'h02));          // bnez not taken
    ins(enc_i(5'b01000, 3'd2, 8'h77));
    ins(enc_r(3'd7, 3'd2, 5'b10000)); exp_ev(16'h0012, 16'h0077, 2'b11, 1'b0);
    ins(enc_i(5'b01001, 3'd3, 8'h80));
    ins(enc_i(5'b10010, 3'd3, 8'h02));          // bmi taken
    ins(enc_i(5'b01000, 3'd2, 8'h11));
    ins({5'b11000, 11'd2});                     // j +2
    ins(enc_i(5'b01000, 3'd2, 8'h22));
    ins(enc_r(3'd7, 3'd2, 5'b10000)); exp_ev(16'h0012, 16'h0077, 2'b11, 1'b0);
    hlt_addr = pa * 2;
    ins({5'b11111, 11'd0});
    ins(enc_r(3'd7, 3'd1, 5'b10000));
    ins(enc_r(3'd7, 3'd1, 5'b10000));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iaddr", {16'd0, iaddr}, 32'h0000_0000);
    check("rst_ioe", {31'd0, ioe}, 32'd0);
    check("rst_dctl", {29'd0, doe, dwe0, dwe1}, 32'd0);
    check("rst_daddr", {16'd0, daddr}, 32'd0);
    check("rst_ddout", {16'd0, ddout}, 32'd0);
    check("rst_finish", {31'd0, dut.finish}, 32'd0);
    rst = 1'b0;
    #1;
    check("fill_ioe", {31'd0, ioe}, 32'd1);
    check("fill_iaddr", {16'd0, iaddr}, 32'd0);

    halted = 1'b0;
    for (int i = 0; i < 400 && !halted; i++) begin
      @(negedge clk);
      if (ioe === 1'b0) halted = 1'b1;
    end
    check("halt_reached", {31'd0, ioe}, 32'd0);
    check("halt_finish", {31'd0, dut.finish}, 32'd1);
    check("halt_state0", {30'd0, dut.state0}, 32'd2);
    repeat (6) @(negedge clk);
    check("halt_iaddr_frozen", {16'd0, iaddr}, hlt_addr + 6);
    check("halt_ioe", {31'd0, ioe}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("first_store_cycle", first_st_cyc, 32'd6);

    rst = 1'b1;
    @(negedge clk);
    check("rerst_iaddr", {16'd0, iaddr}, 32'd0);
    check("rerst_finish", {31'd0, dut.finish}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rerun_ioe", {31'd0, ioe}, 32'd1);
    check("rerun_iaddr", {16'd0, iaddr}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
